// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU-sharing arbiter.
// Optional build macro used elsewhere in this slice: ALU_SHARE_STATS_EN.
package alu_share_pkg;

    localparam int RES_W = 8;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;
    localparam logic [1:0] FN_CAT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the front ends and the ALU-sharing arbiter.
// ALU_SHARE_STATS_EN adds the per-requester op_count vector.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [2*NUM_REQ-1:0] req_func;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [7:0]           rsp_data;
    logic                 busy;
    logic [IDX_W-1:0]     grant_idx;
`ifdef ALU_SHARE_STATS_EN
    logic [8*NUM_REQ-1:0] op_count;
`endif

    modport master (
        output req_valid, req_a, req_b, req_func, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy, grant_idx
`ifdef ALU_SHARE_STATS_EN
        , input op_count
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_func, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy, grant_idx
`ifdef ALU_SHARE_STATS_EN
        , output op_count
`endif
    );
endinterface

// File: rtl/alu_share_arbiter_alu_core.sv
// Combinational 4-bit, four-function ALU shared by all requesters.
// The add is a ripple-carry full-adder chain; its carry-out lands in bit 4.
module alu_core
    import alu_share_pkg::*;
(
    input  logic [3:0]       a_i,
    input  logic [3:0]       b_i,
    input  logic [1:0]       func_i,
    output logic [RES_W-1:0] y_o
);
    logic [4:0] carry;
    logic [3:0] sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    // Function select
    always_comb begin
        y_o = '0;
        case (func_i)
            FN_ADD:  y_o = {3'b000, carry[4], sum};
            FN_OR:   y_o = {7'b0, |(a_i | b_i)};
            FN_AND:  y_o = {7'b0, |(a_i & b_i)};
            FN_CAT:  y_o = {a_i, b_i};
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, one
// operation in flight. Build with ALU_SHARE_STATS_EN for per-requester
// completed-operation counters.
//
//  state | meaning
//  IDLE  | waiting; req_ready offered round-robin from rr_ptr
//  EXEC  | one cycle, ALU result registered into rsp_data
//  RESP  | rsp_valid to owner until its rsp_ready
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 2
) (
    input logic                  clk_sys_i,
    input logic                  rst_b_i,
    alu_share_arbiter_if.slave   bus
);
    state_t             state_q, state_d;
    logic [3:0]         a_q, a_d, b_q, b_d;
    logic [1:0]         func_q, func_d;
    logic [IDX_W-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [RES_W-1:0]   rsp_data_q, rsp_data_d, alu_y;
    logic [NUM_REQ-1:0] owner_mask, req_ready;
    logic               pick_found, rsp_hs;
    logic [IDX_W-1:0]   pick_idx;

    alu_core u_alu (
        .a_i    (a_q),
        .b_i    (b_q),
        .func_i (func_q),
        .y_o    (alu_y)
    );

    assign owner_mask = NUM_REQ'(1) << owner_q;
    assign rsp_hs     = (state_q == RESP) && ((bus.rsp_ready & owner_mask) != '0);

    // Round-robin pick: first valid requester at or after rr_ptr
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && ((bus.req_valid & (NUM_REQ'(1) << cand_idx)) != '0)) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state and request-side outputs
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        func_d     = func_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    req_ready = NUM_REQ'(1) << pick_idx;
                    a_d       = 4'(bus.req_a >> (4 * int'(pick_idx)));
                    b_d       = 4'(bus.req_b >> (4 * int'(pick_idx)));
                    func_d    = 2'(bus.req_func >> (2 * int'(pick_idx)));
                    owner_d   = pick_idx;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_y;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            func_q     <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            func_q     <= func_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == RESP) ? owner_mask : '0;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_idx = owner_q;

`ifdef ALU_SHARE_STATS_EN
    logic [8*NUM_REQ-1:0] op_count_q;

    // Count completed responses per requester, wrapping at 8 bits
    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            op_count_q <= '0;
        end else if (rsp_hs) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == IDX_W'(i)) op_count_q[8*i +: 8] <= op_count_q[8*i +: 8] + 8'd1;
            end
        end
    end

    assign bus.op_count = op_count_q;
`endif
endmodule
